// File: rtl/fifo_drain_pkg.sv
// Shared types and helpers for the fifo_drain read-side adapter.
package fifo_drain_pkg;

  localparam int FRAME_CNT_WIDTH = 16;

  typedef struct packed {
    logic valid;
    logic consent;
  } hs_t;

  // Circular increment that also works for depths that are not a power of two.
  function automatic int unsigned wrapInc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_drain_latency_tracker.sv
// Tags each pop for READ_LATENCY cycles; arrive_o marks the cycle its data is on the read bus.
// No backpressure: it only counts what has already been committed.
module fifo_drain_latency_tracker
  import fifo_drain_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                              clkIn,
  input  logic                              rstNIn,
  input  logic                              pop_i,
  output logic                              arrive_o,
  output logic [$clog2(READ_LATENCY+1)-1:0] inflight_o
);
  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  logic [READ_LATENCY-1:0] vld_q, vld_d;

  assign vld_d    = (vld_q << 1) | READ_LATENCY'(pop_i);
  assign arrive_o = vld_q[READ_LATENCY-1];

  always_comb begin
    inflight_o = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_o = inflight_o + CNT_W'(vld_q[i]);
    end
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// Re-times a fixed-latency read port into a registered valid/consent stream with frame marking.
// Output valid one cycle after data lands; credit-gated pops mean a stalled output never drops data.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int BUF_DEPTH    = 4,
  parameter int FRAME_LEN    = 64
) (
  input  logic                       clkIn,
  input  logic                       rstNIn,
  input  logic                       srcValidIn,
  output logic                       srcConsentOut,
  input  logic [DATA_WIDTH-1:0]      srcDataIn,
  output logic                       outValidOut,
  input  logic                       outConsentIn,
  output logic [DATA_WIDTH-1:0]      outDataOut,
  output logic                       outLastOut,
  output logic [FRAME_CNT_WIDTH-1:0] frameCountOut
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam int POS_W = $clog2(FRAME_LEN);

  logic [DATA_WIDTH-1:0]      mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]           occ_q, occ_d;
  logic [POS_W-1:0]           pos_q, pos_d;
  logic [FRAME_CNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                       cons_q, cons_d;
  logic                       arrive, pop, accept, last;
  logic [LAT_W-1:0]           inflight;
  hs_t                        src_hs, out_hs;

  assign src_hs = '{valid: srcValidIn, consent: cons_q};
  assign out_hs = '{valid: (occ_q != '0), consent: outConsentIn};
  assign pop    = src_hs.valid & src_hs.consent;
  assign accept = out_hs.valid & out_hs.consent;
  assign last   = (pos_q == POS_W'(FRAME_LEN - 1));

  fifo_drain_latency_tracker #(
    .READ_LATENCY(READ_LATENCY)
  ) u_tracker (
    .clkIn     (clkIn),
    .rstNIn    (rstNIn),
    .pop_i     (pop),
    .arrive_o  (arrive),
    .inflight_o(inflight)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pos_d    = pos_q;
    fcnt_d   = fcnt_q;
    occ_d    = occ_q + OCC_W'(arrive) - OCC_W'(accept);
    if (arrive) begin
      wr_ptr_d = PTR_W'(wrapInc(32'(wr_ptr_q), BUF_DEPTH));
    end
    if (accept) begin
      rd_ptr_d = PTR_W'(wrapInc(32'(rd_ptr_q), BUF_DEPTH));
      if (last) begin
        pos_d  = '0;
        fcnt_d = fcnt_q + 1'b1;
      end else begin
        pos_d  = pos_q + 1'b1;
      end
    end
    // Grant next cycle only if everything committed after this edge still leaves a free slot.
    cons_d = (int'(inflight) + int'(pop) - int'(arrive) + int'(occ_d)) < BUF_DEPTH;
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pos_q    <= '0;
      fcnt_q   <= '0;
      cons_q   <= 1'b0;
    end else begin
      if (arrive) begin
        mem_q[wr_ptr_q] <= srcDataIn;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pos_q    <= pos_d;
      fcnt_q   <= fcnt_d;
      cons_q   <= cons_d;
    end
  end

  assign srcConsentOut = cons_q;
  assign outValidOut   = out_hs.valid;
  assign outDataOut    = mem_q[rd_ptr_q];
  assign outLastOut    = out_hs.valid & last;
  assign frameCountOut = fcnt_q;

endmodule

// File: tb/tb_fifo_drain.sv
`timescale 1ns/1ps
module tb_fifo_drain;
  localparam int RL0 = 1, BUF0 = 4, FR0 = 8;
  localparam int RL1 = 3, BUF1 = 5, FR1 = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [1:0]            src_vld, src_cons, out_vld, out_rdy, out_last;
  logic [1:0][31:0]      src_dat, out_dat;
  logic [1:0][15:0]      fcnt;

  fifo_drain #(.DATA_WIDTH(32), .READ_LATENCY(RL0), .BUF_DEPTH(BUF0), .FRAME_LEN(FR0)) u_a (
    .clkIn(clk), .rstNIn(rst_n), .srcValidIn(src_vld[0]), .srcConsentOut(src_cons[0]),
    .srcDataIn(src_dat[0]), .outValidOut(out_vld[0]), .outConsentIn(out_rdy[0]),
    .outDataOut(out_dat[0]), .outLastOut(out_last[0]), .frameCountOut(fcnt[0]));

  fifo_drain #(.DATA_WIDTH(32), .READ_LATENCY(RL1), .BUF_DEPTH(BUF1), .FRAME_LEN(FR1)) u_b (
    .clkIn(clk), .rstNIn(rst_n), .srcValidIn(src_vld[1]), .srcConsentOut(src_cons[1]),
    .srcDataIn(src_dat[1]), .outValidOut(out_vld[1]), .outConsentIn(out_rdy[1]),
    .outDataOut(out_dat[1]), .outLastOut(out_last[1]), .frameCountOut(fcnt[1]));

  // Source RAM model and scoreboard, one lane per DUT.
  logic [1:0][3:0] tag;
  logic [31:0]     dp [2][4];
  int unsigned     seq [2];
  int unsigned     nacc [2];
  int unsigned     q0 [$];
  int unsigned     q1 [$];
  logic [1:0]      cons_exp, popd, acc, acc_last;
  logic [31:0]     acc_dat [2];
  logic [31:0]     exp_dat [2];
  int              cyc;
  int              errors = 0;
  int              checks = 0;

  function automatic int rl(int d);   return (d == 0) ? RL0 : RL1;   endfunction
  function automatic int bufd(int d); return (d == 0) ? BUF0 : BUF1; endfunction
  function automatic int qsize(int d); return (d == 0) ? q0.size() : q1.size(); endfunction
  function automatic int inflight(int d);
    int n = 0;
    for (int i = 0; i < rl(d); i++) n += int'(tag[d][i]);
    return n;
  endfunction
  function automatic int occ(int d); return qsize(d) - inflight(d); endfunction

  task automatic clear_model();
    tag = '0;
    q0.delete();
    q1.delete();
    cons_exp = '0;
    nacc[0] = 0;
    nacc[1] = 0;
  endtask

  // Advance one clock: capture handshakes before the edge, update the model after it.
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      popd[d]     = src_vld[d] & src_cons[d];
      acc[d]      = out_vld[d] & out_rdy[d];
      acc_dat[d]  = out_dat[d];
      acc_last[d] = out_last[d];
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (acc[d]) begin
        nacc[d]++;
        if (qsize(d) == 0) exp_dat[d] = ~acc_dat[d];
        else if (d == 0)   exp_dat[d] = q0.pop_front();
        else               exp_dat[d] = q1.pop_front();
      end
      if (popd[d]) begin
        if (d == 0) q0.push_back(seq[d]);
        else        q1.push_back(seq[d]);
      end
      for (int i = 3; i > 0; i--) begin
        tag[d][i] = tag[d][i-1];
        dp[d][i]  = dp[d][i-1];
      end
      tag[d][0] = popd[d];
      dp[d][0]  = popd[d] ? seq[d] : $urandom;
      if (popd[d]) seq[d]++;
      src_dat[d]  = dp[d][rl(d)-1];
      cons_exp[d] = qsize(d) < bufd(d);
    end
  endtask

  task automatic do_reset();
    src_vld = '0;
    out_rdy = '0;
    rst_n   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (int'(u_a.occ_q) > BUF0 || (u_a.arrive && int'(u_a.occ_q) == BUF0)) begin
        errors++;
        $display("FAIL occ_bound_a: occ=%0d arrive=%0b limit=%0d", u_a.occ_q, u_a.arrive, BUF0);
      end
      checks++;
      if (int'(u_b.occ_q) > BUF1 || (u_b.arrive && int'(u_b.occ_q) == BUF1)) begin
        errors++;
        $display("FAIL occ_bound_b: occ=%0d arrive=%0b limit=%0d", u_b.occ_q, u_b.arrive, BUF1);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; src_vld = '0; out_rdy = '0;
    clear_model();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks += 5;
      if (src_cons[d] !== 1'b0) begin errors++; $display("FAIL rst_cons[%0d]: got %b want 0", d, src_cons[d]); end
      if (out_vld[d]  !== 1'b0) begin errors++; $display("FAIL rst_vld[%0d]: got %b want 0", d, out_vld[d]); end
      if (out_dat[d]  !== 32'd0) begin errors++; $display("FAIL rst_dat[%0d]: got %h want 0", d, out_dat[d]); end
      if (out_last[d] !== 1'b0) begin errors++; $display("FAIL rst_last[%0d]: got %b want 0", d, out_last[d]); end
      if (fcnt[d]     !== 16'd0) begin errors++; $display("FAIL rst_fcnt[%0d]: got %0d want 0", d, fcnt[d]); end
    end
    rst_n = 1'b1;
    repeat (2) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (src_cons[d] !== cons_exp[d]) begin errors++; $display("FAIL post_rst_cons[%0d]: got %b want %b", d, src_cons[d], cons_exp[d]); end
      end
    end
  endtask

  task automatic test_stream();
    int pop_cyc = -1, vld_cyc = -1, n = 0, gaps = 0;
    do_reset();
    seq[0] = 0;
    src_vld[0] = 1'b1; out_rdy[0] = 1'b1;
    for (int c = 0; c < 400 && n < 200; c++) begin
      if (pop_cyc < 0 && src_vld[0] && src_cons[0]) pop_cyc = cyc;
      step();
      if (acc[0]) begin
        n++; checks++;
        if (acc_dat[0] !== exp_dat[0]) begin errors++; $display("FAIL stream_data: got %0d want %0d", acc_dat[0], exp_dat[0]); end
      end
      if (vld_cyc < 0 && out_vld[0]) vld_cyc = cyc;
      else if (vld_cyc >= 0 && n < 200 && !out_vld[0]) gaps++;
    end
    checks += 3;
    if (n != 200) begin errors++; $display("FAIL stream_count: got %0d want 200", n); end
    if (vld_cyc - pop_cyc != RL0 + 1) begin errors++; $display("FAIL stream_latency: got %0d want %0d", vld_cyc - pop_cyc, RL0 + 1); end
    if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_stall();
    logic [31:0] hold_dat;
    logic        hold_vld;
    int          n = 0;
    out_rdy[0] = 1'b0;
    hold_dat = out_dat[0];
    hold_vld = out_vld[0];
    repeat (20) begin
      step();
      checks += 3;
      if (out_dat[0] !== hold_dat) begin errors++; $display("FAIL stall_dat: got %h want %h", out_dat[0], hold_dat); end
      if (out_vld[0] !== hold_vld) begin errors++; $display("FAIL stall_vld: got %b want %b", out_vld[0], hold_vld); end
      if (src_cons[0] !== cons_exp[0]) begin errors++; $display("FAIL stall_cons: got %b want %b", src_cons[0], cons_exp[0]); end
    end
    checks++;
    if (src_cons[0] !== 1'b0) begin errors++; $display("FAIL stall_cons_low: got %b want 0", src_cons[0]); end
    out_rdy[0] = 1'b1;
    for (int c = 0; c < 100 && n < 30; c++) begin
      step();
      if (acc[0]) begin
        n++; checks++;
        if (acc_dat[0] !== exp_dat[0]) begin errors++; $display("FAIL resume_data: got %0d want %0d", acc_dat[0], exp_dat[0]); end
      end
    end
    checks++;
    if (n != 30) begin errors++; $display("FAIL resume_count: got %0d want 30", n); end
  endtask

  task automatic test_frame();
    int k = 0;
    do_reset();
    src_vld[0] = 1'b1; out_rdy[0] = 1'b1;
    for (int c = 0; c < 100 && k < 24; c++) begin
      step();
      if (acc[0]) begin
        k++; checks += 3;
        if (acc_last[0] !== ((k % FR0) == 0)) begin errors++; $display("FAIL frame_last@%0d: got %b want %b", k, acc_last[0], (k % FR0) == 0); end
        if (fcnt[0] !== 16'(k / FR0)) begin errors++; $display("FAIL frame_count@%0d: got %0d want %0d", k, fcnt[0], k / FR0); end
        if (acc_dat[0] !== exp_dat[0]) begin errors++; $display("FAIL frame_data: got %0d want %0d", acc_dat[0], exp_dat[0]); end
      end
    end
    checks++;
    if (k != 24) begin errors++; $display("FAIL frame_accepts: got %0d want 24", k); end
  endtask

  task automatic test_full_simul();
    int c = 0;
    do_reset();
    src_vld[0] = 1'b1; out_rdy[0] = 1'b0;
    while (c < 30 && !(qsize(0) == BUF0 && inflight(0) == 1)) begin step(); c++; end
    out_rdy[0] = 1'b1;
    checks += 3;
    if (src_cons[0] !== 1'b0) begin errors++; $display("FAIL full_cons: got %b want 0", src_cons[0]); end
    if (u_a.arrive !== 1'b1) begin errors++; $display("FAIL full_arrive: got %b want 1", u_a.arrive); end
    if (int'(u_a.occ_q) != occ(0)) begin errors++; $display("FAIL full_occ_pre: got %0d want %0d", u_a.occ_q, occ(0)); end
    step();
    checks += 3;
    if (acc[0] !== 1'b1 || acc_dat[0] !== exp_dat[0]) begin errors++; $display("FAIL full_accept: got %0d want %0d", acc_dat[0], exp_dat[0]); end
    if (int'(u_a.occ_q) != BUF0 - 1) begin errors++; $display("FAIL full_occ_post: got %0d want %0d", u_a.occ_q, BUF0 - 1); end
    if (src_cons[0] !== cons_exp[0]) begin errors++; $display("FAIL full_cons_post: got %b want %b", src_cons[0], cons_exp[0]); end
    src_vld[0] = 1'b0; out_rdy[0] = 1'b0;
  endtask

  task automatic test_random();
    int n = 0;
    do_reset();
    for (int c = 0; c < 20000 && n < 1000; c++) begin
      src_vld[1] = 1'($urandom_range(0, 1));
      out_rdy[1] = ($urandom_range(0, 3) != 0);
      step();
      checks += 2;
      if (src_cons[1] !== cons_exp[1]) begin errors++; $display("FAIL rand_cons: got %b want %b", src_cons[1], cons_exp[1]); end
      if (out_vld[1] !== (occ(1) != 0)) begin errors++; $display("FAIL rand_vld: got %b want %b", out_vld[1], occ(1) != 0); end
      if (acc[1]) begin
        n++; checks++;
        if (acc_dat[1] !== exp_dat[1]) begin errors++; $display("FAIL rand_data: got %0d want %0d", acc_dat[1], exp_dat[1]); end
      end
    end
    checks += 2;
    if (n != 1000) begin errors++; $display("FAIL rand_count: got %0d want 1000", n); end
    if (fcnt[1] !== 16'(nacc[1] / FR1)) begin errors++; $display("FAIL rand_fcnt: got %0d want %0d", fcnt[1], nacc[1] / FR1); end
  endtask

  task automatic test_reset_inflight();
    int c = 0;
    src_vld[1] = 1'b0; out_rdy[1] = 1'b1;
    while (c < 50 && qsize(1) != 0) begin
      step(); c++;
      if (acc[1]) begin
        checks++;
        if (acc_dat[1] !== exp_dat[1]) begin errors++; $display("FAIL drain_data: got %0d want %0d", acc_dat[1], exp_dat[1]); end
      end
    end
    out_rdy[1] = 1'b0; src_vld[1] = 1'b1; c = 0;
    while (c < 30 && !(inflight(1) == 2 && occ(1) == 3)) begin step(); c++; end
    checks++;
    if (c >= 30) begin errors++; $display("FAIL fill_timeout: got inflight=%0d occ=%0d want 2/3", inflight(1), occ(1)); end
    src_vld[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (src_cons[1] !== 1'b0) begin errors++; $display("FAIL arst_cons: got %b want 0", src_cons[1]); end
    if (out_vld[1]  !== 1'b0) begin errors++; $display("FAIL arst_vld: got %b want 0", out_vld[1]); end
    if (out_dat[1]  !== 32'd0) begin errors++; $display("FAIL arst_dat: got %h want 0", out_dat[1]); end
    if (out_last[1] !== 1'b0) begin errors++; $display("FAIL arst_last: got %b want 0", out_last[1]); end
    if (fcnt[1]     !== 16'd0) begin errors++; $display("FAIL arst_fcnt: got %0d want 0", fcnt[1]); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    repeat (RL1 + 2) begin
      step();
      checks++;
      if (out_vld[1] !== 1'b0) begin errors++; $display("FAIL stale_vld: got %b want 0", out_vld[1]); end
    end
    src_vld[1] = 1'b1; out_rdy[1] = 1'b1; c = 0;
    while (c < 20 && !acc[1]) begin step(); c++; end
    checks++;
    if (!acc[1] || acc_dat[1] !== exp_dat[1]) begin errors++; $display("FAIL fresh_data: got %0d want %0d", acc_dat[1], exp_dat[1]); end
  endtask

  initial begin
    rst_n = 1'b0;
    src_vld = '0; out_rdy = '0; src_dat = '0;
    tag = '0; cons_exp = '0; cyc = 0;
    seq[0] = 0; seq[1] = 32'h1000;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) dp[d][i] = '0;
    test_reset();
    test_stream();
    test_stall();
    test_frame();
    test_full_simul();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
